// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
//
// Bundles the two requester ports and the SRAM controller port that meet at
// the sram_arbiter. Every signal is a plain logic; the interface carries no
// clock because the arbiter's clk/rst stay scalar ports.
//
// Signal summary:
//   pN_wr_en, pN_rd_en   requester N write / read request levels
//   pN_address           requester N byte address
//   pN_write_data        requester N write data
//   pN_read_data         read data returned to requester N
//   pN_freeze            stall for requester N
//   pN_ready             one-cycle completion pulse for requester N
//   mem_wr_en, mem_rd_en enables to the SRAM controller
//   mem_address          address to the SRAM controller
//   mem_write_data       write data to the SRAM controller
//   mem_read_data        read data from the SRAM controller
//   mem_ready            one-cycle done pulse from the SRAM controller
//
// Modports:
//   master  the arbiter's view (drives requester responses and mem_* commands)
//   slave   the surroundings' view (requesters plus SRAM controller)
//
// Handshake: a requester holds wr_en/rd_en (and its address/data) as a level
// for as long as it wants service; pN_ready pulses for exactly one cycle when
// its transaction finishes, and pN_freeze is high in every requesting cycle
// except that one. Toward the controller, mem_*_en is a level held until the
// cycle mem_ready pulses, and is dropped at that very clock edge.
// ---------------------------------------------------------------------------
interface sram_arbiter_if;
  logic        p0_wr_en;
  logic        p0_rd_en;
  logic [31:0] p0_address;
  logic [31:0] p0_write_data;
  logic [31:0] p0_read_data;
  logic        p0_freeze;
  logic        p0_ready;

  logic        p1_wr_en;
  logic        p1_rd_en;
  logic [31:0] p1_address;
  logic [31:0] p1_write_data;
  logic [31:0] p1_read_data;
  logic        p1_freeze;
  logic        p1_ready;

  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  modport master (
    input  p0_wr_en, p0_rd_en, p0_address, p0_write_data,
    output p0_read_data, p0_freeze, p0_ready,
    input  p1_wr_en, p1_rd_en, p1_address, p1_write_data,
    output p1_read_data, p1_freeze, p1_ready,
    output mem_wr_en, mem_rd_en, mem_address, mem_write_data,
    input  mem_read_data, mem_ready
  );

  modport slave (
    output p0_wr_en, p0_rd_en, p0_address, p0_write_data,
    input  p0_read_data, p0_freeze, p0_ready,
    output p1_wr_en, p1_rd_en, p1_address, p1_write_data,
    input  p1_read_data, p1_freeze, p1_ready,
    input  mem_wr_en, mem_rd_en, mem_address, mem_write_data,
    output mem_read_data, mem_ready
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one SRAM controller between two requesters: port 0 is the MEM-stage
// data port, port 1 a secondary master (instruction / debug loader). Whole
// transactions are serialised; a requester is frozen from the first cycle it
// asks until its completion pulse. A watchdog aborts a transaction that sees
// no mem_ready for TIMEOUT cycles and raises a sticky fault flag.
//
// Parameters:
//   TIMEOUT     cycles in BUSY without mem_ready before abort (>= 8)
//   CNT_W       watchdog counter width (2**CNT_W > TIMEOUT)
//   FIXED_PRIO  0 = round-robin, 1 = port 0 always wins
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   bus          sram_arbiter_if.master: both requester ports + SRAM port
//   owner        port currently / last granted (1 out of reset)
//   timeout_err  sticky watchdog fault, cleared only by reset
//   state_dbg    FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: requests are levels; a grant is taken only in IDLE; the granted
// port's fields are latched at the grant edge and held through BUSY. pN_ready
// is a single-cycle pulse that coincides with mem_ready (or the watchdog
// expiry), and pN_freeze = reqN & ~pN_ready.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int TIMEOUT    = 32,
  parameter int CNT_W      = 6,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_arbiter_if.master        bus,
  output logic                  owner,
  output logic                  timeout_err,
  output logic                  state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        req0;
  logic        req1;
  logic        req_any;
  logic        winner;
  logic        win_rd;
  logic [31:0] win_address;
  logic [31:0] win_write_data;
  logic        timeout_hit;
  logic        done;

  // -------------------------------------------------------------------------
  // Request decode and winner selection (only consumed in IDLE)
  // -------------------------------------------------------------------------
  always_comb begin
    req0    = bus.p0_wr_en | bus.p0_rd_en;
    req1    = bus.p1_wr_en | bus.p1_rd_en;
    req_any = req0 | req1;

    winner = 1'b0;
    if (FIXED_PRIO != 0) begin
      winner = ~req0;
    end else if (req0 && req1) begin
      // Tie: the port that did not have the last grant goes next. owner
      // resets to 1, so port 0 takes the first tie.
      winner = ~owner;
    end else begin
      winner = req1;
    end

    // A port raising both enables is served as a read, so exactly one mem
    // enable is ever set.
    if (winner) begin
      win_rd         = bus.p1_rd_en;
      win_address    = bus.p1_address;
      win_write_data = bus.p1_write_data;
    end else begin
      win_rd         = bus.p0_rd_en;
      win_address    = bus.p0_address;
      win_write_data = bus.p0_write_data;
    end
  end

  // -------------------------------------------------------------------------
  // Completion: mem_ready wins over an expiring watchdog in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    timeout_hit = (state == BUSY) && !bus.mem_ready && (cnt == CNT_LAST);
    done        = (state == BUSY) && (bus.mem_ready || timeout_hit);
  end

  // -------------------------------------------------------------------------
  // Requester-side responses
  // -------------------------------------------------------------------------
  always_comb begin
    bus.p0_ready = done && !owner;
    bus.p1_ready = done &&  owner;

    // An aborted transaction returns zero rather than whatever the hung
    // controller happens to present.
    bus.p0_read_data = (!owner && !timeout_hit) ? bus.mem_read_data : 32'h0;
    bus.p1_read_data = ( owner && !timeout_hit) ? bus.mem_read_data : 32'h0;

    // Freeze covers waiting for the other port too; it drops only in the
    // ready cycle. A withdrawn request is never frozen.
    bus.p0_freeze = req0 && !bus.p0_ready;
    bus.p1_freeze = req1 && !bus.p1_ready;

    state_dbg = (state == BUSY);
  end

  // -------------------------------------------------------------------------
  // FSM with registered SRAM command outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      bus.mem_wr_en      <= 1'b0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_address    <= 32'h0;
      bus.mem_write_data <= 32'h0;
      owner              <= 1'b1;
      cnt                <= '0;
      timeout_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            bus.mem_address    <= win_address;
            bus.mem_write_data <= win_write_data;
            bus.mem_rd_en      <= win_rd;
            bus.mem_wr_en      <= ~win_rd;
            owner              <= winner;
            cnt                <= '0;
            state              <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            // Enables must fall on this edge so the controller's return to
            // idle does not see a fresh request and re-launch the access.
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            state         <= IDLE;
          end else if (timeout_hit) begin
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            timeout_err   <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
